// File: rtl/seg_pkg.sv
// Shared types and the hex-to-segment table for the seven-segment display block.
// Segment bits are a..g from bit 0 and active-high here; output polarity is applied by the top.
package seg_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'h00;

  // Entry 0 is the rightmost element, so the list reads F down to 0.
  localparam logic [15:0][6:0] HEX_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39,  // F E d C
    7'h7C, 7'h77, 7'h6F, 7'h7F,  // b A 9 8
    7'h07, 7'h7D, 7'h6D, 7'h66,  // 7 6 5 4
    7'h4F, 7'h5B, 7'h06, 7'h3F   // 3 2 1 0
  };

endpackage

// File: rtl/hex_seg_lut.sv
// Combinational hex digit to active-high seven-segment pattern.
// Zero latency; no flow control.
module hex_seg_lut
  import seg_pkg::*;
(
  input  logic [3:0] hex,
  output seg_t       seg
);

  assign seg = HEX_TABLE[hex];

endmodule

// File: rtl/seg_display_ctrl.sv
// Hex display driver: static per-digit segments plus an optional multiplexed scan output.
// All outputs are registered one cycle after the held data; the block has no backpressure.
module seg_display_ctrl
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 50000,
  parameter int BLINK_DIV  = 25000000,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    Load,
  input  logic [4*NUM_DIGITS-1:0] Value,
  input  logic                    BlankLZ,
  input  logic [NUM_DIGITS-1:0]   BlinkMask,
  input  logic                    Mode,
  output logic [7*NUM_DIGITS-1:0] Seg,
  output logic [6:0]              ScanSeg,
  output logic [NUM_DIGITS-1:0]   DigitEn
);

  localparam int SW = $clog2(SCAN_DIV);
  localparam int BW = $clog2(BLINK_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  // XOR mask that converts active-high patterns to the pin polarity; also the "off" level.
  localparam seg_t                  SEG_OFF = {7{ACTIVE_LOW != 0}};
  localparam logic [NUM_DIGITS-1:0] EN_OFF  = {NUM_DIGITS{ACTIVE_LOW != 0}};

  logic [4*NUM_DIGITS-1:0] data_q;
  logic [SW-1:0]           scan_cnt;
  logic [IW-1:0]           idx;
  logic [BW-1:0]           blink_cnt;
  logic                    phase;

  seg_t                    raw   [NUM_DIGITS];
  seg_t                    seg_d [NUM_DIGITS];
  logic [7*NUM_DIGITS-1:0] seg_flat;
  logic [NUM_DIGITS-1:0]   en_hot;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      data_q <= '0;
    end else if (Load) begin
      data_q <= Value;
    end
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_lut
    hex_seg_lut u_lut (
      .hex (data_q[4*g +: 4]),
      .seg (raw[g])
    );
  end

  // Walk from the most significant digit; blanking stops at the first nonzero digit.
  always_comb begin
    logic lz;
    logic blank;
    lz       = BlankLZ;
    blank    = 1'b0;
    seg_flat = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      blank = 1'b0;
      if (k != 0 && lz && data_q[4*k +: 4] == 4'h0) begin
        blank = 1'b1;
      end else begin
        lz = 1'b0;
      end
      if (phase && BlinkMask[k]) begin
        blank = 1'b1;
      end
      seg_d[k]          = blank ? (SEG_BLANK ^ SEG_OFF) : (raw[k] ^ SEG_OFF);
      seg_flat[7*k +: 7] = seg_d[k];
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt <= '0;
      phase     <= ~phase;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  // Static mode parks the scan at digit 0 so re-entering scan gives a full first dwell.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      scan_cnt <= '0;
      idx      <= '0;
    end else if (!Mode) begin
      scan_cnt <= '0;
      idx      <= '0;
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt <= '0;
      idx      <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  always_comb begin
    en_hot      = '0;
    en_hot[idx] = 1'b1;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      Seg     <= {NUM_DIGITS{SEG_BLANK ^ SEG_OFF}};
      ScanSeg <= SEG_BLANK ^ SEG_OFF;
      DigitEn <= EN_OFF;
    end else begin
      Seg     <= seg_flat;
      ScanSeg <= Mode ? seg_d[idx] : (SEG_BLANK ^ SEG_OFF);
      DigitEn <= Mode ? (en_hot ^ EN_OFF) : EN_OFF;
    end
  end

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Directed self-checking bench for seg_display_ctrl (4 digits, scan 4, blink 16, active-low).
module tb_seg_display_ctrl;

  localparam logic [6:0] L0  = 7'h40;
  localparam logic [6:0] L1  = 7'h79;
  localparam logic [6:0] L2  = 7'h24;
  localparam logic [6:0] LA  = 7'h08;
  localparam logic [6:0] LC  = 7'h46;
  localparam logic [6:0] LF  = 7'h0E;
  localparam logic [6:0] BLK = 7'h7F;

  logic        Clk;
  logic        Reset;
  logic        Load;
  logic [15:0] Value;
  logic        BlankLZ;
  logic [3:0]  BlinkMask;
  logic        Mode;
  logic [27:0] Seg;
  logic [6:0]  ScanSeg;
  logic [3:0]  DigitEn;

  int pass_cnt = 0;
  int total    = 0;

  seg_display_ctrl #(
    .NUM_DIGITS (4),
    .SCAN_DIV   (4),
    .BLINK_DIV  (16),
    .ACTIVE_LOW (1)
  ) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Load      (Load),
    .Value     (Value),
    .BlankLZ   (BlankLZ),
    .BlinkMask (BlinkMask),
    .Mode      (Mode),
    .Seg       (Seg),
    .ScanSeg   (ScanSeg),
    .DigitEn   (DigitEn)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic tick;
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic pulse_reset;
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  function automatic logic [3:0] en_of(input int i);
    logic [3:0] e;
    e    = 4'hF;
    e[i] = 1'b0;
    return e;
  endfunction

  function automatic logic [6:0] digit_12af(input int i);
    logic [6:0] d;
    case (i)
      0:       d = LF;
      1:       d = LA;
      2:       d = L2;
      default: d = L1;
    endcase
    return d;
  endfunction

  task automatic test_reset;
    #3;
    total++;
    if (Seg !== {4{BLK}} || ScanSeg !== BLK || DigitEn !== 4'hF)
      $display("FAIL reset_hold: Seg=%h ScanSeg=%h DigitEn=%b, want %h %h 1111", Seg, ScanSeg, DigitEn, {4{BLK}}, BLK);
    else pass_cnt++;
    @(negedge Clk);
    Reset = 1'b0;
    tick();
    total++;
    if (Seg !== {L0, L0, L0, L0})
      $display("FAIL reset_first_edge: Seg=%h want %h", Seg, {L0, L0, L0, L0});
    else pass_cnt++;
  endtask

  task automatic test_lz_zero;
    BlankLZ = 1'b1; Value = 16'h0000; Load = 1'b1;
    tick();
    Load = 1'b0;
    tick();
    total++;
    if (Seg !== {BLK, BLK, BLK, L0})
      $display("FAIL lz_zero: Seg=%h want %h", Seg, {BLK, BLK, BLK, L0});
    else pass_cnt++;
  endtask

  task automatic test_lz_c0;
    BlankLZ = 1'b1; Value = 16'h00C0; Load = 1'b1;
    tick();
    Load = 1'b0;
    tick();
    total++;
    if (Seg !== {BLK, BLK, LC, L0})
      $display("FAIL lz_c0_on: Seg=%h want %h", Seg, {BLK, BLK, LC, L0});
    else pass_cnt++;
    BlankLZ = 1'b0;
    tick();
    total++;
    if (Seg !== {L0, L0, LC, L0})
      $display("FAIL lz_c0_off: Seg=%h want %h", Seg, {L0, L0, LC, L0});
    else pass_cnt++;
    BlankLZ = 1'b1; Value = 16'h0102; Load = 1'b1;
    tick();
    Load = 1'b0;
    tick();
    total++;
    if (Seg !== {BLK, L1, L0, L2})
      $display("FAIL lz_inner_zero: Seg=%h want %h", Seg, {BLK, L1, L0, L2});
    else pass_cnt++;
  endtask

  task automatic test_latency;
    BlankLZ = 1'b0; Value = 16'h12AF; Load = 1'b1;
    tick();
    Load = 1'b0;
    total++;
    if (Seg !== {L0, L1, L0, L2})
      $display("FAIL latency_old: Seg=%h want %h", Seg, {L0, L1, L0, L2});
    else pass_cnt++;
    tick();
    total++;
    if (Seg !== {L1, L2, LA, LF})
      $display("FAIL latency_new: Seg=%h want %h", Seg, {L1, L2, LA, LF});
    else pass_cnt++;
    total++;
    if (ScanSeg !== BLK || DigitEn !== 4'hF)
      $display("FAIL static_mode: ScanSeg=%h DigitEn=%b want %h 1111", ScanSeg, DigitEn, BLK);
    else pass_cnt++;
  endtask

  task automatic test_scan;
    Mode = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      int i;
      tick();
      i = ((k - 1) / 4) % 4;
      total++;
      if (DigitEn !== en_of(i) || ScanSeg !== digit_12af(i))
        $display("FAIL scan_k%0d: DigitEn=%b ScanSeg=%h want %b %h", k, DigitEn, ScanSeg, en_of(i), digit_12af(i));
      else pass_cnt++;
    end
  endtask

  task automatic test_mode_switch;
    tick();
    tick();
    total++;
    if (DigitEn !== 4'b1101 || ScanSeg !== LA)
      $display("FAIL mode_mid_dwell: DigitEn=%b ScanSeg=%h want 1101 %h", DigitEn, ScanSeg, LA);
    else pass_cnt++;
    Mode = 1'b0;
    tick();
    total++;
    if (DigitEn !== 4'hF || ScanSeg !== BLK || Seg !== {L1, L2, LA, LF})
      $display("FAIL mode_off: DigitEn=%b ScanSeg=%h Seg=%h want 1111 %h %h", DigitEn, ScanSeg, Seg, BLK, {L1, L2, LA, LF});
    else pass_cnt++;
    Mode = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      int i;
      tick();
      i = (k - 1) / 4;
      total++;
      if (DigitEn !== en_of(i) || ScanSeg !== digit_12af(i))
        $display("FAIL mode_restart_k%0d: DigitEn=%b ScanSeg=%h want %b %h", k, DigitEn, ScanSeg, en_of(i), digit_12af(i));
      else pass_cnt++;
    end
  endtask

  task automatic test_blink;
    Mode = 1'b0;
    pulse_reset();
    Value = 16'h12AF; Load = 1'b1; BlankLZ = 1'b0; BlinkMask = 4'b0010;
    tick();
    Load = 1'b0;
    for (int k = 2; k <= 50; k++) begin
      logic [6:0] d1;
      tick();
      d1 = ((((k - 1) / 16) % 2) == 1) ? BLK : LA;
      total++;
      if (Seg !== {L1, L2, d1, LF})
        $display("FAIL blink_k%0d: Seg=%h want %h", k, Seg, {L1, L2, d1, LF});
      else pass_cnt++;
    end
    BlinkMask = 4'b0000;
  endtask

  task automatic test_back_to_back;
    Mode = 1'b1;
    pulse_reset();
    Value = 16'h12AF; BlankLZ = 1'b0; Load = 1'b0;
    tick();
    total++;
    if (DigitEn !== 4'b1110 || ScanSeg !== L0)
      $display("FAIL wrap_first: DigitEn=%b ScanSeg=%h want 1110 %h", DigitEn, ScanSeg, L0);
    else pass_cnt++;
    tick();
    tick();
    Load = 1'b1;
    tick();
    Load = 1'b0;
    total++;
    if (DigitEn !== 4'b1110 || ScanSeg !== L0)
      $display("FAIL wrap_edge: DigitEn=%b ScanSeg=%h want 1110 %h", DigitEn, ScanSeg, L0);
    else pass_cnt++;
    tick();
    total++;
    if (DigitEn !== 4'b1101 || ScanSeg !== LA || Seg !== {L1, L2, LA, LF})
      $display("FAIL wrap_load: DigitEn=%b ScanSeg=%h Seg=%h want 1101 %h %h", DigitEn, ScanSeg, Seg, LA, {L1, L2, LA, LF});
    else pass_cnt++;
    tick();
    #2;
    Reset = 1'b1;
    #1;
    total++;
    if (Seg !== {4{BLK}} || ScanSeg !== BLK || DigitEn !== 4'hF)
      $display("FAIL async_reset: Seg=%h ScanSeg=%h DigitEn=%b want %h %h 1111", Seg, ScanSeg, DigitEn, {4{BLK}}, BLK);
    else pass_cnt++;
    @(negedge Clk);
    Reset = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      int i;
      tick();
      i = (k - 1) / 4;
      total++;
      if (DigitEn !== en_of(i) || ScanSeg !== L0)
        $display("FAIL reset_resume_k%0d: DigitEn=%b ScanSeg=%h want %b %h", k, DigitEn, ScanSeg, en_of(i), L0);
      else pass_cnt++;
    end
  endtask

  initial begin
    Reset     = 1'b1;
    Load      = 1'b0;
    Value     = 16'h0000;
    BlankLZ   = 1'b0;
    BlinkMask = 4'b0000;
    Mode      = 1'b0;
    test_reset();
    test_lz_zero();
    test_lz_c0();
    test_latency();
    test_scan();
    test_mode_switch();
    test_blink();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/seg_display_ctrl.md
SEG_DISPLAY_CTRL -- requirements
Module: seg_display_ctrl

Interface
REQ-001 Parameter NUM_DIGITS, default 4, number of hex digits driven (1..8).
REQ-002 Parameter SCAN_DIV, default 50000, Clk cycles per scanned digit (>=2).
REQ-003 Parameter BLINK_DIV, default 25000000, Clk cycles per blink half-period (>=2).
REQ-004 Parameter ACTIVE_LOW, default 1, 1 = segment/enable asserted as 0.
REQ-005 Clk  input  1  single clock; all state on rising edge.
REQ-006 Reset  input  1  asynchronous, active-high reset.
REQ-007 Load  input  1  when 1 at an edge, Value is captured.
REQ-008 Value  input  4*NUM_DIGITS  hex digits, digit 0 in bits [3:0].
REQ-009 BlankLZ  input  1  enable leading-zero blanking.
REQ-010 BlinkMask  input  NUM_DIGITS  per-digit blink enable.
REQ-011 Mode  input  1  0 = static only, 1 = static plus multiplexed scan.
REQ-012 Seg  output  7*NUM_DIGITS  registered per-digit segments, digit k in bits [7k+6:7k], bit order a..g from LSB.
REQ-013 ScanSeg  output  7  registered segments of currently scanned digit.
REQ-014 DigitEn  output  NUM_DIGITS  registered one-hot digit enable for scan mode.

Function
REQ-015 Held data register SHALL load Value on any edge with Load=1, otherwise hold.
REQ-016 Encoding SHALL be hex 0-F: 0=abcdef, 1=bc, 2=abdeg, 3=abcdg, 4=bcfg, 5=acdfg, 6=acdefg, 7=abc, 8=all, 9=abcdfg, A=abcefg, b=cdefg, C=adef, d=bcdeg, E=adefg, F=aefg; polarity per ACTIVE_LOW.
REQ-017 Blank digit SHALL drive all seven segments deasserted.
REQ-018 With BlankLZ=1, digits from NUM_DIGITS-1 downward SHALL be blanked while zero, up to the first nonzero digit; digit 0 SHALL never be LZ-blanked.
REQ-019 Blink phase SHALL toggle every BLINK_DIV cycles; in phase 1, digits with BlinkMask bit set SHALL be blank.
REQ-020 Seg SHALL reflect held data, BlankLZ, BlinkMask and phase with exactly one cycle latency (Load at edge N visible after edge N+1).
REQ-021 Mode=1: scan counter SHALL count 0..SCAN_DIV-1; on wrap, digit index SHALL advance modulo NUM_DIGITS (NUM_DIGITS-1 -> 0).
REQ-022 Mode=1: DigitEn SHALL assert only the bit of the current index; ScanSeg SHALL equal that digit's Seg slice, same cycle as DigitEn.
REQ-023 Mode=0: scan counter and index SHALL be held at 0, DigitEn all deasserted, ScanSeg blank; Seg unaffected.
REQ-024 Mode 0->1 SHALL start scanning at digit 0 with a full SCAN_DIV dwell.
REQ-025 Load coincident with scan wrap or blink toggle SHALL apply both; next output uses new data and new index/phase.
REQ-026 Counters SHALL be sized by $clog2 of their divisor; no other arithmetic.

Reset
REQ-027 Reset=1 SHALL immediately clear data register, scan counter, digit index and blink phase to 0, independent of Clk.
REQ-028 During reset Seg and ScanSeg SHALL be blank and DigitEn deasserted.
REQ-029 First edge after Reset release SHALL produce Seg for value 0 (digit 0 shows "0"; others "0" or blank per BlankLZ).
REQ-030 Reset asserted mid-dwell SHALL abandon the dwell; scan restarts at digit 0.

Structure
REQ-031 Package seg_pkg SHALL hold seg_t (7-bit) typedef, SEG_BLANK constant and the 16-entry hex-to-segment table.
REQ-032 One combinational sub-module hex_seg_lut (4-bit in, seg_t out, active-high) SHALL be instantiated per digit; polarity applied in seg_display_ctrl.

Verification (NUM_DIGITS=4, SCAN_DIV=4, BLINK_DIV=16, ACTIVE_LOW=1)
REQ-033 Reset, then Load Value=16'h0000, BlankLZ=1 -> Seg digit0=7'b1000000 (a..g LSB-first, active-low "0"), digits 1-3 =7'h7F.
REQ-034 Load 16'h12AF, Mode=1 -> DigitEn cycles 1110,1101,1011,0111 every 4 cycles; ScanSeg shows F,A,2,1; wraps to 1110.
REQ-035 Load 16'h00C0, BlankLZ=1 -> digits 3,2 blank, digit1 shows C, digit0 shows 0; BlankLZ=0 -> all four shown.
REQ-036 BlinkMask=4'b0010 -> digit1 blank for 16 cycles, shown for 16, repeating; other digits steady.
REQ-037 Load asserted on scan-wrap edge -> next ScanSeg uses new value; Reset pulsed mid-dwell -> outputs blank asynchronously, scan resumes at digit 0 after release.
